// File: rtl/vga_pkg.sv
// Shared VGA definitions: display geometry, pixel type and prefetch states.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } prefetch_state_e;

  // Plain-vector views of the states for logic that keeps state as a bit vector
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_REQ   = REQ;
  localparam logic [1:0] ST_FLUSH = FLUSH;

endpackage

// File: rtl/vga_pixel_prefetch_if.sv
// Frame-memory read port: req/ack address phase, in-order rvalid data phase.
interface vga_pixel_prefetch_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 19
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with a registered read port; a pop on empty returns black.
module pixel_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A full FIFO refuses a push even if a pop frees a slot in the same cycle
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clock) begin
    if (push_ok && !clear) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (pop_ok) begin
        pop_data <= store[rd_ptr];
      end else if (pop) begin
        pop_data <= '0;
      end

      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push_ok, pop_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// Raster-order pixel prefetcher: keeps a small FIFO topped up from frame memory
// using credits, and restarts at pixel 0 on every frame-start pulse.
module vga_pixel_prefetch #(
  parameter int DATA_W       = 24,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 read_en,
  output logic [DATA_W-1:0]    data,
  vga_pixel_prefetch_if.master mem,
  output logic                 underflow,
  output logic                 overflow
);

  import vga_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]        state;
  logic              flush_pending;
  logic [CNT_W-1:0]  outstanding;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W:0]    in_flight;
  logic              credit;
  logic              ack_ok;
  logic              ret_ok;
  logic              push;
  logic              flush_done;

  // Buffered plus in-flight pixels bound the FIFO, so a legal memory cannot overflow it
  assign in_flight  = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit     = (in_flight < (CNT_W + 1)'(DEPTH));
  assign ack_ok     = (state == ST_REQ) & mem.mem_ack;
  assign ret_ok     = mem.mem_rvalid & (outstanding != '0);
  assign push       = mem.mem_rvalid & (state != ST_FLUSH);
  assign flush_done = (state == ST_FLUSH) & (outstanding == '0);

  assign mem.mem_req  = (state == ST_REQ);
  assign mem.mem_addr = addr;

  pixel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush_done),
    .push      (push),
    .push_data (mem.mem_rdata),
    .pop       (read_en),
    .pop_data  (data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      flush_pending <= 1'b0;
      outstanding   <= '0;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_pending) begin
            state <= ST_FLUSH;
          end else if (credit) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem.mem_ack) begin
            state <= ST_IDLE;
            addr  <= (addr == ADDR_W'(FRAME_PIXELS - 1)) ? '0 : addr + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (outstanding == '0) begin
            state <= ST_IDLE;
            addr  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A pulse arriving while a flush is already running is absorbed by it
      if (flush_done) begin
        flush_pending <= 1'b0;
      end else if (frame_start && (state != ST_FLUSH)) begin
        flush_pending <= 1'b1;
      end

      case ({ack_ok, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (read_en && fifo_empty) begin
        underflow <= 1'b1;
      end
      if (push && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
